// File: rtl/led_status_arbiter.sv
// Four-requester priority arbiter for one shared status LED with minimum grant hold.
// Define LED_STATUS_ARB_PREEMPT_EN to let a higher-priority request take the grant without waiting for hold expiry.
module led_status_arbiter #(
   parameter int    CLK_FREQ_HZ = 125000000,
   parameter int    TICK_HZ     = 1000,
   parameter int    HOLD_TICKS  = 2000,
   parameter string IS_DEBUG    = "false"
) (
   input  logic        i_clk,
   input  logic        i_a_rst_n,
   input  logic [3:0]  i_req,
   input  logic [11:0] i_pattern,
   output logic        o_led,
   output logic [3:0]  o_grant,
   output logic        o_busy
);

   localparam int DIV = (IS_DEBUG == "true") ? 4 : (CLK_FREQ_HZ / TICK_HZ);
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HW  = $clog2(HOLD_TICKS + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
   localparam logic [9:0]    PHASE_MAX = 10'd999;

`ifdef LED_STATUS_ARB_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   typedef enum logic {IDLE, ACTIVE} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q;
   logic [9:0]    phase_q, phase_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [3:0]    grant_q, grant_d;
   logic          led_q, led_d;

   logic          tick;
   logic          ownerReq;
   logic          higherReq;
   logic          holdExpired;
   logic          grantChange;
   logic [2:0]    ownerPattern;

   function automatic logic [3:0] prioPick(input logic [3:0] r);
      return r & (~r + 4'd1);
   endfunction

   function automatic logic patternOn(input logic [2:0] code, input logic [9:0] phase);
      logic on;
      case (code)
         3'd1:    on = 1'b1;
         3'd2:    on = (phase < 10'd500);
         3'd3:    on = ((phase % 10'd200) < 10'd100);
         3'd4:    on = (phase < 10'd100) || ((phase >= 10'd200) && (phase < 10'd300));
         default: on = 1'b0;
      endcase
      return on;
   endfunction

   assign tick        = (presc_q == PRESC_MAX);
   assign ownerReq    = |(i_req & grant_q);
   // With a one-hot owner, grant-1 masks exactly the bits of higher priority.
   assign higherReq   = |(i_req & (grant_q - 4'd1));
   assign holdExpired = (hold_q == HOLD_MAX);

   always_comb begin
      grant_d = grant_q;
      case (state_q)
         IDLE:    grant_d = prioPick(i_req);
         ACTIVE: begin
            if (!ownerReq || (higherReq && (holdExpired || PREEMPT))) begin
               grant_d = prioPick(i_req);
            end
         end
         default: grant_d = 4'd0;
      endcase
   end

   assign state_d     = (grant_d != 4'd0) ? ACTIVE : IDLE;
   assign grantChange = (grant_d != grant_q);

   always_comb begin
      phase_d = phase_q;
      hold_d  = hold_q;
      if (grantChange) begin
         phase_d = 10'd0;
         hold_d  = '0;
      end else if (tick) begin
         phase_d = (phase_q == PHASE_MAX) ? 10'd0 : phase_q + 10'd1;
         if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
         end
      end
   end

   always_comb begin
      ownerPattern = 3'd0;
      case (grant_q)
         4'b0001: ownerPattern = i_pattern[2:0];
         4'b0010: ownerPattern = i_pattern[5:3];
         4'b0100: ownerPattern = i_pattern[8:6];
         4'b1000: ownerPattern = i_pattern[11:9];
         default: ownerPattern = 3'd0;
      endcase
   end

   // The LED follows the registered owner, so it trails o_grant by one cycle.
   assign led_d = patternOn(ownerPattern, phase_q);

   always_ff @(posedge i_clk or negedge i_a_rst_n) begin
      if (!i_a_rst_n) begin
         state_q <= IDLE;
         presc_q <= '0;
         phase_q <= 10'd0;
         hold_q  <= '0;
         grant_q <= 4'd0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= tick ? '0 : presc_q + PW'(1);
         phase_q <= phase_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
         led_q   <= led_d;
      end
   end

   assign o_grant = grant_q;
   assign o_led   = led_q;
   assign o_busy  = |grant_q;

endmodule
